// File: rtl/llc_conflict_replay_buf_pkg.sv
// Shared LLC types and constants used by the conflict replay buffer and its interface.
package llc_conflict_replay_buf_pkg;

    localparam int unsigned LINE_ADDR_BITS  = 16;
    localparam int unsigned LLC_SET_BITS    = 8;
    localparam int unsigned N_CONFLICT_BUF  = 4;
    localparam int unsigned CONFLICT_INFO_W = 8;

    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [LLC_SET_BITS-1:0]   llc_set_t;

    typedef struct packed {
        line_addr_t                 addr;
        logic [CONFLICT_INFO_W-1:0] info;
        logic                       ready;
    } llc_conflict_entry_t;

endpackage

// File: rtl/llc_conflict_replay_buf_if.sv
// Push / wake / replay bundle between the request path, the MSHR retire logic and the conflict buffer.
interface llc_conflict_replay_buf_if
    import llc_conflict_replay_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = N_CONFLICT_BUF,
    parameter int unsigned INFO_W = CONFLICT_INFO_W
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              push_valid;
    logic              push_ready;
    line_addr_t        push_addr;
    logic [INFO_W-1:0] push_info;
    logic              wake_valid;
    llc_set_t          wake_set;
    logic              set_conflict;
    line_addr_t        conflict_addr;
    logic [INFO_W-1:0] conflict_info;
    logic              set_req_from_conflict;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              err_pop;

    modport master (
        output push_valid, push_addr, push_info, wake_valid, wake_set, set_req_from_conflict,
        input  push_ready, set_conflict, conflict_addr, conflict_info, count, full, empty, err_pop
    );

    modport slave (
        input  push_valid, push_addr, push_info, wake_valid, wake_set, set_req_from_conflict,
        output push_ready, set_conflict, conflict_addr, conflict_info, count, full, empty, err_pop
    );

endinterface

// File: rtl/llc_conflict_replay_buf.sv
// In-order replay buffer for LLC requests blocked on a set owned by an in-flight MSHR.
module llc_conflict_replay_buf
    import llc_conflict_replay_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = N_CONFLICT_BUF,
    parameter int unsigned INFO_W = CONFLICT_INFO_W
) (
    input logic                      clk,
    input logic                      rst,
    llc_conflict_replay_buf_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    line_addr_t        addr_q [DEPTH];
    logic [INFO_W-1:0] info_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  ready_q;
    logic [DEPTH-1:0]  wake_hit;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;
    logic              full_w;
    logic              empty_w;
    logic              sc_w;
    logic              do_push;
    logic              do_pop;
    logic              push_wake;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        assign wake_hit[g] = bus.wake_valid && valid_q[g] &&
                             (addr_q[g][LLC_SET_BITS-1:0] == bus.wake_set);
    end

    always_comb begin
        full_w    = (count_q == CNT_W'(DEPTH));
        empty_w   = (count_q == '0);
        sc_w      = !empty_w && ready_q[rd_ptr];
        do_push   = bus.push_valid && !full_w;
        do_pop    = bus.set_req_from_conflict && sc_w;
        push_wake = bus.wake_valid && (bus.push_addr[LLC_SET_BITS-1:0] == bus.wake_set);
    end

    // Storage (addr/info) is deliberately left out of reset; only the valid/ready bookkeeping clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
            ready_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wake_hit[i]) ready_q[i] <= 1'b1;
            end
            // Pop is applied after wake so a same-cycle wake on the head cannot resurrect it.
            if (do_pop) begin
                valid_q[rd_ptr] <= 1'b0;
                ready_q[rd_ptr] <= 1'b0;
                rd_ptr          <= ptr_next(rd_ptr);
            end
            if (do_push) begin
                addr_q[wr_ptr]  <= bus.push_addr;
                info_q[wr_ptr]  <= bus.push_info;
                valid_q[wr_ptr] <= 1'b1;
                ready_q[wr_ptr] <= push_wake;
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
            if (bus.set_req_from_conflict && !sc_w) err_q <= 1'b1;
        end
    end

    assign bus.push_ready    = !full_w;
    assign bus.set_conflict  = sc_w;
    assign bus.conflict_addr = addr_q[rd_ptr];
    assign bus.conflict_info = info_q[rd_ptr];
    assign bus.count         = count_q;
    assign bus.full          = full_w;
    assign bus.empty         = empty_w;
    assign bus.err_pop       = err_q;

endmodule

// File: tb/tb_llc_conflict_replay_buf.sv
// Bench for llc_conflict_replay_buf: directed vector table, hand sequences and random traffic vs a queue model.
module tb_llc_conflict_replay_buf;
    localparam int DEPTH  = 4;
    localparam int INFO_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    llc_conflict_replay_buf_if #(.DEPTH(DEPTH), .INFO_W(INFO_W)) bus ();

    llc_conflict_replay_buf #(.DEPTH(DEPTH), .INFO_W(INFO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  info;
        bit          ready;
    } m_entry_t;

    m_entry_t m_q[$];
    bit       m_err;

    typedef struct {
        logic        rst;
        logic        pv;
        logic [15:0] addr;
        logic [7:0]  info;
        logic        wv;
        logic [7:0]  ws;
        logic        pop;
        int          cnt;
        logic        sc;
        logic        err;
        logic [15:0] eaddr;
        logic [7:0]  einfo;
    } vec_t;

    vec_t vt[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference behaviour: a FIFO queue whose head may leave only once its set has been released.
    function automatic void model_update(logic r, logic pv, logic [15:0] a, logic [7:0] inf,
                                         logic wv, logic [7:0] ws, logic pop);
        bit head_ok;
        bit was_full;
        if (r) begin
            m_q.delete();
            m_err = 1'b0;
            return;
        end
        head_ok  = (m_q.size() > 0) && m_q[0].ready;
        was_full = (m_q.size() == DEPTH);
        if (wv) begin
            foreach (m_q[i]) if (m_q[i].addr[7:0] == ws) m_q[i].ready = 1'b1;
        end
        if (pop && head_ok) void'(m_q.pop_front());
        else if (pop) m_err = 1'b1;
        if (pv && !was_full) m_q.push_back('{a, inf, wv && (a[7:0] == ws)});
    endfunction

    task automatic step(logic r, logic pv, logic [15:0] a, logic [7:0] inf,
                        logic wv, logic [7:0] ws, logic pop);
        rst                       = r;
        bus.push_valid            = pv;
        bus.push_addr             = a;
        bus.push_info             = inf;
        bus.wake_valid            = wv;
        bus.wake_set              = ws;
        bus.set_req_from_conflict = pop;
        @(posedge clk);
        model_update(r, pv, a, inf, wv, ws, pop);
        #1;
        rst                       = 1'b0;
        bus.push_valid            = 1'b0;
        bus.wake_valid            = 1'b0;
        bus.set_req_from_conflict = 1'b0;
    endtask

    task automatic check_model(string tag);
        bit exp_sc;
        exp_sc = (m_q.size() > 0) && m_q[0].ready;
        chk({tag, ".count"}, 32'(bus.count), 32'(m_q.size()));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(m_q.size() == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(m_q.size() == DEPTH));
        chk({tag, ".push_ready"}, 32'(bus.push_ready), 32'(m_q.size() != DEPTH));
        chk({tag, ".set_conflict"}, 32'(bus.set_conflict), 32'(exp_sc));
        chk({tag, ".err_pop"}, 32'(bus.err_pop), 32'(m_err));
        if (exp_sc) begin
            chk({tag, ".conflict_addr"}, 32'(bus.conflict_addr), 32'(m_q[0].addr));
            chk({tag, ".conflict_info"}, 32'(bus.conflict_info), 32'(m_q[0].info));
        end
    endtask

    function automatic void add(logic r, logic pv, logic [15:0] a, logic [7:0] inf, logic wv,
                                logic [7:0] ws, logic pop, int cnt, logic sc, logic err,
                                logic [15:0] ea, logic [7:0] ei);
        vt.push_back('{r, pv, a, inf, wv, ws, pop, cnt, sc, err, ea, ei});
    endfunction

    initial begin
        bus.push_valid            = 1'b0;
        bus.push_addr             = '0;
        bus.push_info             = '0;
        bus.wake_valid            = 1'b0;
        bus.wake_set              = '0;
        bus.set_req_from_conflict = 1'b0;
        m_err                     = 1'b0;

        //   rst pv addr     info   wv ws     pop  cnt sc err eaddr    einfo
        add(0, 1, 16'h0123, 8'hA1, 0, 8'h00, 0,  1, 0, 0, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h23, 0,  1, 1, 0, 16'h0123, 8'hA1);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 1,  0, 0, 0, 16'h0000, 8'h00);
        add(0, 1, 16'h0210, 8'hB0, 0, 8'h00, 0,  1, 0, 0, 16'h0000, 8'h00);
        add(0, 1, 16'h0311, 8'hB1, 0, 8'h00, 0,  2, 0, 0, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h11, 0,  2, 0, 0, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h10, 0,  2, 1, 0, 16'h0210, 8'hB0);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 1,  1, 1, 0, 16'h0311, 8'hB1);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 1,  0, 0, 0, 16'h0000, 8'h00);
        add(1, 0, 16'h0000, 8'h00, 0, 8'h00, 0,  0, 0, 0, 16'h0000, 8'h00);
        add(0, 1, 16'h1001, 8'hC1, 0, 8'h00, 0,  1, 0, 0, 16'h0000, 8'h00);
        add(0, 1, 16'h1002, 8'hC2, 0, 8'h00, 0,  2, 0, 0, 16'h0000, 8'h00);
        add(0, 1, 16'h1003, 8'hC3, 0, 8'h00, 0,  3, 0, 0, 16'h0000, 8'h00);
        add(0, 1, 16'h1004, 8'hC4, 0, 8'h00, 0,  4, 0, 0, 16'h0000, 8'h00);
        add(0, 1, 16'h1005, 8'hC5, 0, 8'h00, 0,  4, 0, 0, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h01, 0,  4, 1, 0, 16'h1001, 8'hC1);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h02, 0,  4, 1, 0, 16'h1001, 8'hC1);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h03, 0,  4, 1, 0, 16'h1001, 8'hC1);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h04, 0,  4, 1, 0, 16'h1001, 8'hC1);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 1,  3, 1, 0, 16'h1002, 8'hC2);
        add(0, 1, 16'h1006, 8'hC6, 0, 8'h00, 1,  3, 1, 0, 16'h1003, 8'hC3);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 1,  2, 1, 0, 16'h1004, 8'hC4);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 1,  1, 0, 0, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h06, 0,  1, 1, 0, 16'h1006, 8'hC6);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 1,  0, 0, 0, 16'h0000, 8'h00);
        add(0, 1, 16'h0705, 8'hD5, 1, 8'h05, 0,  1, 1, 0, 16'h0705, 8'hD5);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 1,  0, 0, 0, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 1,  0, 0, 1, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 0, 8'h00, 0,  0, 0, 1, 16'h0000, 8'h00);
        add(0, 1, 16'h0140, 8'hE0, 0, 8'h00, 0,  1, 0, 1, 16'h0000, 8'h00);
        add(0, 1, 16'h0141, 8'hE1, 0, 8'h00, 0,  2, 0, 1, 16'h0000, 8'h00);
        add(0, 1, 16'h0142, 8'hE2, 0, 8'h00, 0,  3, 0, 1, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h40, 0,  3, 1, 1, 16'h0140, 8'hE0);
        add(1, 0, 16'h0000, 8'h00, 0, 8'h00, 0,  0, 0, 0, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h40, 0,  0, 0, 0, 16'h0000, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 1, 8'h41, 0,  0, 0, 0, 16'h0000, 8'h00);

        // reset state
        step(1, 0, '0, '0, 0, '0, 0);
        step(1, 0, '0, '0, 0, '0, 0);
        chk("rst.count", 32'(bus.count), 0);
        chk("rst.empty", 32'(bus.empty), 1);
        chk("rst.full", 32'(bus.full), 0);
        chk("rst.push_ready", 32'(bus.push_ready), 1);
        chk("rst.set_conflict", 32'(bus.set_conflict), 0);
        chk("rst.err_pop", 32'(bus.err_pop), 0);

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].pv, vt[i].addr, vt[i].info, vt[i].wv, vt[i].ws, vt[i].pop);
            chk($sformatf("vec%0d.count", i), 32'(bus.count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(vt[i].cnt == 0));
            chk($sformatf("vec%0d.full", i), 32'(bus.full), 32'(vt[i].cnt == DEPTH));
            chk($sformatf("vec%0d.push_ready", i), 32'(bus.push_ready), 32'(vt[i].cnt != DEPTH));
            chk($sformatf("vec%0d.set_conflict", i), 32'(bus.set_conflict), 32'(vt[i].sc));
            chk($sformatf("vec%0d.err_pop", i), 32'(bus.err_pop), 32'(vt[i].err));
            if (vt[i].sc) begin
                chk($sformatf("vec%0d.conflict_addr", i), 32'(bus.conflict_addr), 32'(vt[i].eaddr));
                chk($sformatf("vec%0d.conflict_info", i), 32'(bus.conflict_info), 32'(vt[i].einfo));
            end
        end

        // full buffer with push+pop together: push must be dropped, pop still taken
        step(1, 0, '0, '0, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 16'h0520 + 16'(i), 8'h60 + 8'(i), 1, 8'h20 + 8'(i), 0);
            check_model("fill");
        end
        step(0, 1, 16'h0599, 8'h99, 0, '0, 1);
        check_model("fullpp");
        chk("fullpp.count", 32'(bus.count), 3);
        chk("fullpp.head", 32'(bus.conflict_addr), 32'h0521);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, '0, 0, '0, 1);
            check_model("drain");
        end
        chk("drain.count", 32'(bus.count), 0);

        // pop held high continuously on a ready stream: one pop per cycle
        step(1, 0, '0, '0, 0, '0, 0);
        step(0, 1, 16'h0830, 8'h30, 1, 8'h30, 0);
        step(0, 1, 16'h0831, 8'h31, 1, 8'h31, 1);
        check_model("b2b");
        step(0, 0, '0, '0, 0, '0, 1);
        check_model("b2b");
        chk("b2b.empty", 32'(bus.empty), 1);

        // randomized traffic against the queue model
        step(1, 0, '0, '0, 0, '0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        r, pv, wv, pop;
            logic [15:0] a;
            logic [7:0]  ws;
            r   = ($urandom_range(0, 199) == 0);
            pv  = ($urandom_range(0, 99) < 50);
            wv  = ($urandom_range(0, 99) < 35);
            pop = ($urandom_range(0, 99) < 45);
            a   = {8'($urandom), 8'($urandom_range(0, 5))};
            ws  = 8'($urandom_range(0, 5));
            step(r, pv, a, 8'($urandom), wv, ws, pop);
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/llc_conflict_replay_buf.md
Name: llc_conflict_replay_buf

Overview:
- Buffers LLC requests that hit a set conflict (target set already owned by an in-flight MSHR) and replays them to llc_input_decoder in arrival order.
- Sits beside the request input path, directly upstream of llc_input_decoder.
- Drives set_conflict plus the replay address and info. Consumes set_req_from_conflict as the pop strobe.
- Entries become replayable when a response retires the conflicting set (wake).

Parameters:
DEPTH, 4, number of buffered conflicting requests (>=2, need not be a power of 2)
INFO_W, 8, width of opaque request info carried with each entry (coh msg, req id)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
push_valid  in  1  conflicting request to enqueue
push_ready  out  1  buffer can accept a push (= !full)
push_addr  in  LINE_ADDR_BITS  line address of conflicting request
push_info  in  INFO_W  request info
wake_valid  in  1  a transaction on wake_set has retired
wake_set  in  LLC_SET_BITS  set index being released
set_conflict  out  1  head entry is valid and ready for replay
conflict_addr  out  LINE_ADDR_BITS  head line address
conflict_info  out  INFO_W  head info
set_req_from_conflict  in  1  decoder accepted head this cycle (pop)
count  out  $clog2(DEPTH+1)  number of valid entries
full  out  1  count == DEPTH
empty  out  1  count == 0
err_pop  out  1  sticky: pop received while set_conflict low

Behaviour:
- Clock and reset: one clock, clk. Reset port rst is synchronous and active-high. All state updates on posedge clk; rst takes priority over every other input.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, all valid/ready bits 0, err_pop=0. Outputs after reset: empty=1, full=0, push_ready=1, set_conflict=0.
- conflict_addr/conflict_info: reflect head storage at all times. They are don't-care when set_conflict=0 and are not cleared by reset.
- Storage: circular buffer of DEPTH entries {addr, info, ready}.
  - Pointers wrap from DEPTH-1 to 0.
  - count is held explicitly; no pointer-extension trick.
- Push: occurs when push_valid && push_ready. Entry written at wr_ptr with ready=0, then wr_ptr advances. push_valid while full is ignored: no write, no error.
- Wake: when wake_valid is high, every valid entry with addr[LLC_SET_BITS-1:0]==wake_set sets ready=1 next cycle. Tag is ignored. Wake is level-per-cycle and idempotent.
- Push and wake in the same cycle: if push_addr's set equals wake_set, the pushed entry is written with ready=1.
- set_conflict: combinational from registers, = !empty && ready[rd_ptr]. Replay is strictly in order, so a ready non-head entry waits behind a non-ready head (head-of-line blocking is intended).
- Pop: occurs when set_req_from_conflict && set_conflict. The head valid/ready bits clear and rd_ptr advances. Outputs reflect the new head in the next cycle, so pop-to-next-set_conflict latency is 1 cycle minimum.
- set_req_from_conflict while set_conflict=0: no state change; err_pop set sticky until rst.
- Push and pop in the same cycle: both take effect and count is unchanged.
  - Full with pop: push_ready is still 0 that cycle; no pass-through.
  - Empty with push: the pushed entry is not poppable until the next cycle (set_conflict depends only on registered state).
- Wake and pop in the same cycle on the head: the pop wins and the entry is cleared.
- count, full, empty: registered-state derived, with no combinational path from push/pop inputs.
- Reset mid-operation: all entries discarded and no replay is issued. Upstream must re-present any dropped requests.

Decomposition:
- In the shared consts/types package:
  - line_addr_t, llc_set_t, LINE_ADDR_BITS, LLC_SET_BITS (existing)
  - new typedef llc_conflict_entry_t {line_addr_t addr; logic [INFO_W-1:0] info; logic ready;}
  - constant N_CONFLICT_BUF (default DEPTH).
- No sub-module needed. The set-match logic is a generate loop producing a per-entry wake_hit vector inside the block.

Test Plan (DEPTH=4):
1. Reset, then push addr 0x0123 (set 0x23); no wake -> set_conflict stays 0, count=1, empty=0. Then wake_set=0x23 -> set_conflict=1 next cycle, conflict_addr=0x0123.
2. Push sets 0x10, 0x11; wake 0x11 only -> set_conflict=0 (head not ready). Then wake 0x10 -> head replays. Pop -> next cycle set_conflict=1 with the 0x11 entry.
3. Push 4 entries -> full=1, push_ready=0. A 5th push_valid is dropped. Wake all, pop once -> count=3. Push plus pop in the same cycle -> count stays 3 and wr_ptr wraps to 1.
4. Push set 0x05 and wake_valid with wake_set=0x05 in the same cycle -> entry ready; set_conflict=1 on the following cycle.
5. Pop while empty -> err_pop=1, count stays 0, err_pop stays 1 until rst.
6. With 3 entries stored, assert rst for 1 cycle -> count=0, empty=1, set_conflict=0, err_pop=0; a subsequent wake produces no set_conflict.
